fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32E pipeline.
- Owns the program counter and issues word reads to instruction memory over a request/response handshake with variable latency.
- Presents pc0/pc4/instruction plus an invalid flag to the IF/ID pipeline register.
- Honours the hazard-unit stall and the EX-stage redirect (taken branch/jump). A one-entry hold buffer keeps a returned instruction alive across stalls.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  IF/ID hold request from hazard unit
- redirect  input  1  EX redirect (taken branch/jump); overrides stall
- redirect_target  input  32  new PC; bits [1:0] ignored (forced 0)
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ready  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response valid (≥1 cycle after acceptance)
- imem_rdata  input  32  instruction word
- pc0_IF  output  32  address of presented instruction
- pc4_IF  output  32  pc0_IF + 4 (mod 2^32)
- instruction_IF  output  32  presented instruction
- invalid_IF  output  1  no usable instruction this cycle

Behaviour:
- Registers: pc (address of the next or outstanding fetch), state, hold_instr.
- Reset values: pc=RESET_VECTOR, state=IDLE. While rst=1: imem_req=0, invalid_IF=1, instruction_IF=0, pc0_IF=RESET_VECTOR.
- At most one outstanding request. A request is accepted when imem_req&imem_ready. imem_addr=pc, except on the same-cycle chained reissue below.
- present_valid: (WAIT & imem_rvalid) or HOLD. Instruction source is imem_rdata (bypass) or hold_instr. pc0_IF=pc in both cases.
- consume = present_valid & !stall & !redirect.
- invalid_IF = redirect | (!stall & !present_valid). It must be 0 whenever stall=1 and redirect=0, because IF/ID must not overwrite its held instruction with a NOP.
- States and transitions:
  - IDLE: imem_req=1 (0 if redirect). Accepted -> WAIT.
  - WAIT: waiting for the response.
    - rvalid & consume: pc<=pc+4. In the same cycle, drive imem_req=1 with imem_addr=pc+4. Accepted -> WAIT, else -> IDLE.
    - rvalid & stall & !redirect: hold_instr<=imem_rdata -> HOLD.
    - rvalid & redirect: drop the response -> IDLE.
    - no rvalid & redirect -> DRAIN.
  - HOLD: present hold_instr, imem_req=0. consume -> chained reissue as in WAIT. redirect -> IDLE.
  - DRAIN: imem_req=0, invalid_IF=1 unless stall. On rvalid, discard -> IDLE. A further redirect in DRAIN updates pc only.
- Any redirect: pc<=redirect_target&~3, imem_req=0 that cycle. A response already in flight is always drained and discarded, never presented.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.
- Throughput: 1 instr/cycle with a 1-cycle, always-ready memory. Each extra memory wait cycle adds one invalid bubble.
- Reset asserted mid-request: state and pc reset immediately. A late imem_rvalid arriving in IDLE is ignored. The memory model must not respond to requests issued before reset.

Decomposition:
- Shared package (core_pkg) holds:
  - fetch_state_t enum {IDLE, WAIT, HOLD, DRAIN}
  - NOP_INSTR = 32'h13
  - XLEN = 32
  - the RESET_VECTOR default
- No sub-module. The hold buffer is a single register inside the block.

Test Plan:
- Reset release, 1-cycle always-ready memory returning addr as data -> first presentation pc0_IF=0, instruction_IF=0, then 4, 8, 12 on consecutive cycles with invalid_IF=0.
- Memory latency 3 cycles -> invalid_IF=1 for 2 cycles between instructions. imem_req is never high while a request is outstanding (except on a chained reissue).
- stall=1 for 4 cycles while the response for pc=8 arrives -> invalid_IF=0 throughout, no new request issued. After release, pc0_IF=8 is presented once, then the fetch of 12.
- redirect=1 target=32'h100 while a request for 0x10 is outstanding -> DRAIN. The 0x10 response is never presented. Next request addr=0x100, and invalid_IF=1 in the redirect cycle.
- redirect and stall in the same cycle -> invalid_IF=1 and pc <= target. A redirect_target of 32'h103 fetches 32'h100.
- pc=32'hFFFF_FFFC consumed -> pc4_IF=0 and the next imem_addr=0. Async rst pulse mid-WAIT -> pc=RESET_VECTOR immediately and a late rvalid is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32E pipeline front end
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch with one outstanding request and a one-entry hold buffer
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc0_IF,
  output logic [XLEN-1:0] pc4_IF,
  output logic [XLEN-1:0] instruction_IF,
  output logic            invalid_IF
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d, pc_inc;
  logic present_valid, consume, accepted;
  assign pc_inc = pc_q + 32'd4;
  assign present_valid = (state_q == WAIT && imem_rvalid) || state_q == HOLD;
  assign consume = present_valid && !stall && !redirect;
  // a consumed instruction immediately chains the fetch of the following word
  assign imem_req = !rst && !redirect && (state_q == IDLE || consume);
  assign imem_addr = consume ? pc_inc : pc_q;
  assign accepted = imem_req && imem_ready;
  assign pc0_IF = pc_q;
  assign pc4_IF = pc_inc;
  assign instruction_IF = !present_valid ? '0 : state_q == HOLD ? hold_q : imem_rdata;
  // a stalled IF/ID keeps its own instruction, so no bubble is signalled while stalling
  assign invalid_IF = rst || redirect || (!stall && !present_valid);
  // next-state: fetch sequencing, hold capture on stall, drain of responses made stale by a redirect
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    hold_d = hold_q;
    unique case (state_q)
      IDLE: if (accepted) state_d = WAIT;
      WAIT:
        if (imem_rvalid) state_d = consume ? (accepted ? WAIT : IDLE) : redirect ? IDLE : HOLD;
        else if (redirect) state_d = DRAIN;
      HOLD:
        if (consume) state_d = accepted ? WAIT : IDLE;
        else if (redirect) state_d = IDLE;
      DRAIN: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == WAIT && imem_rvalid && stall && !redirect) hold_d = imem_rdata;
    if (consume) pc_d = pc_inc;
    if (redirect) pc_d = redirect_target & ~32'h3;
  end
  // state registers, asynchronously returned to the reset vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_VECTOR;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch-stage bench checked against an in-order instruction stream model
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_target = '0, imem_rdata = '0;
  logic imem_req, invalid_IF;
  logic [31:0] imem_addr, pc0_IF, pc4_IF, instruction_IF;
  int vectors = 0, errors = 0, consumed = 0;
  logic [31:0] exp_pc = '0;
  bit out_v = 0;
  logic [31:0] out_a = '0;
  int out_cnt = 0;
  int lat_lo = 1, lat_hi = 1, rdy_pct = 100;
  bit spurious = 0;
  bit s_req, s_acc, s_invalid, s_cons;
  logic [31:0] s_addr, s_pc4;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc0_IF(pc0_IF), .pc4_IF(pc4_IF), .instruction_IF(instruction_IF),
    .invalid_IF(invalid_IF)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: memory answers with data equal to the address; every consumed instruction
  // must be the next word of the program stream, every accepted fetch must target that word.
  task automatic drive(input bit st, input bit rd, input logic [31:0] tgt);
    @(negedge clk);
    stall = st;
    redirect = rd;
    redirect_target = tgt;
    imem_ready = spurious ? 1'b0 : ($urandom_range(99) < rdy_pct);
    imem_rvalid = spurious || (out_v && out_cnt == 0);
    imem_rdata = spurious ? 32'hDEAD_BEEF : imem_rvalid ? out_a : $urandom;
    #1;
    s_req = imem_req;
    s_addr = imem_addr;
    s_pc4 = pc4_IF;
    s_invalid = invalid_IF;
    s_acc = imem_req === 1'b1 && imem_ready;
    s_cons = 0;
    if (rd) begin
      vectors++;
      if (invalid_IF !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL redirect_cycle: invalid_IF=%b imem_req=%b, required 1/0", invalid_IF, imem_req);
      end
      exp_pc = tgt & ~32'h3;
    end else if (st) begin
      vectors++;
      if (invalid_IF !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_bubble: invalid_IF=%b, required 0", invalid_IF);
      end
    end else if (invalid_IF === 1'b0) begin
      s_cons = 1;
      consumed++;
      vectors++;
      if (pc0_IF !== exp_pc || pc4_IF !== exp_pc + 32'd4 || instruction_IF !== exp_pc) begin
        errors++;
        $display("FAIL present: pc0=%h pc4=%h instr=%h, required %h/%h/%h",
                 pc0_IF, pc4_IF, instruction_IF, exp_pc, exp_pc + 32'd4, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_req === 1'b1) begin
      vectors++;
      if (out_v && !imem_rvalid) begin
        errors++;
        $display("FAIL req_outstanding: imem_req=1 with request to %h outstanding, required 0", out_a);
      end
    end
    if (s_acc) begin
      vectors++;
      if (imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL fetch_addr: imem_addr=%h, required %h", imem_addr, exp_pc);
      end
    end
    @(posedge clk);
    if (imem_rvalid) out_v = 0;
    else if (out_v && out_cnt > 0) out_cnt--;
    if (s_acc) begin
      out_v = 1;
      out_a = s_addr;
      out_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (imem_req !== 1'b0 || invalid_IF !== 1'b1 || instruction_IF !== 32'h0 || pc0_IF !== 32'h0) begin
      errors++;
      $display("FAIL %s: req=%b invalid=%b instr=%h pc0=%h, required 0/1/0/0",
               tag, imem_req, invalid_IF, instruction_IF, pc0_IF);
    end
  endtask

  task automatic wait_cons(input string tag);
    for (int k = 0; k < 40 && !s_cons; k++) drive(0, 0, '0);
    vectors++;
    if (!s_cons) begin
      errors++;
      $display("FAIL %s: no instruction presented within 40 cycles, required one", tag);
    end
  endtask

  task automatic wait_acc(input string tag, input logic [31:0] addr);
    for (int k = 0; k < 40 && !s_acc; k++) drive(0, 0, '0);
    vectors++;
    if (!s_acc || s_addr !== addr) begin
      errors++;
      $display("FAIL %s: accepted=%b addr=%h, required 1/%h", tag, s_acc, s_addr, addr);
    end
  endtask

  task automatic test_reset();
    stall = 1'b1;
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    exp_pc = '0;
    out_v = 0;
  endtask

  task automatic test_sequential();
    lat_lo = 1; lat_hi = 1; rdy_pct = 100;
    drive(0, 0, '0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, '0);
      vectors++;
      if (s_invalid !== 1'b0) begin
        errors++;
        $display("FAIL seq_throughput: invalid_IF=%b on cycle %0d, required 0", s_invalid, i);
      end
    end
  endtask

  task automatic test_latency();
    int last = -1, n = 0;
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, '0);
      if (s_cons) begin
        if (n >= 2) begin
          vectors++;
          if (i - last != 3) begin
            errors++;
            $display("FAIL latency_gap: %0d cycles between instructions, required 3", i - last);
          end
        end
        last = i;
        n++;
      end
    end
    vectors++;
    if (n < 8) begin
      errors++;
      $display("FAIL latency_progress: %0d instructions, required >= 8", n);
    end
  endtask

  task automatic test_stall();
    drive(0, 1, 32'h0);
    for (int k = 0; k < 40 && !(out_v && out_a == 32'h8); k++) drive(0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, '0);
      vectors++;
      if (s_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_req: imem_req=%b in stall cycle %0d, required 0", s_req, i);
      end
    end
    drive(0, 0, '0);
    vectors++;
    if (!s_cons || exp_pc !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: presented=%b next_pc=%h, required 1/0000000c", s_cons, exp_pc);
    end
    drive(0, 0, '0);
    wait_cons("stall_next");
    vectors++;
    if (exp_pc !== 32'h10) begin
      errors++;
      $display("FAIL stall_next_pc: next_pc=%h, required 00000010", exp_pc);
    end
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 40 && !(out_v && out_a == 32'h10); k++) drive(0, 0, '0);
    drive(0, 1, 32'h100);
    wait_acc("redirect_fetch", 32'h100);
    drive(0, 0, '0);
    wait_cons("redirect_present");
    vectors++;
    if (exp_pc !== 32'h104) begin
      errors++;
      $display("FAIL redirect_present_pc: next_pc=%h, required 00000104", exp_pc);
    end
  endtask

  task automatic test_redirect_stall();
    drive(1, 1, 32'h103);
    wait_acc("redir_stall_fetch", 32'h100);
    drive(0, 0, '0);
    wait_cons("redir_stall_present");
    vectors++;
    if (exp_pc !== 32'h104) begin
      errors++;
      $display("FAIL redir_stall_pc: next_pc=%h, required 00000104", exp_pc);
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 32'hFFFF_FFFC);
    wait_acc("wrap_fetch", 32'hFFFF_FFFC);
    drive(0, 0, '0);
    wait_cons("wrap_present");
    vectors++;
    if (s_pc4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc4: pc4_IF=%h, required 00000000", s_pc4);
    end
    wait_acc("wrap_next_fetch", 32'h0);
  endtask

  task automatic test_random();
    int start = consumed;
    lat_lo = 1; lat_hi = 4; rdy_pct = 70;
    for (int i = 0; i < 500; i++)
      drive($urandom_range(99) < 30, $urandom_range(99) < 8, $urandom);
    vectors++;
    if (consumed - start < 40) begin
      errors++;
      $display("FAIL random_progress: %0d instructions, required >= 40", consumed - start);
    end
  endtask

  task automatic test_async_reset();
    lat_lo = 3; lat_hi = 3; rdy_pct = 100;
    drive(0, 1, 32'h40);
    for (int k = 0; k < 40 && !out_v; k++) drive(0, 0, '0);
    #3;
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    out_v = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = '0;
    spurious = 1;
    drive(0, 0, '0);
    spurious = 0;
    vectors++;
    if (s_invalid !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid: invalid_IF=%b, required 1", s_invalid);
    end
    wait_acc("post_reset_fetch", 32'h0);
    drive(0, 0, '0);
    wait_cons("post_reset_present");
    vectors++;
    if (exp_pc !== 32'h4) begin
      errors++;
      $display("FAIL post_reset_pc: next_pc=%h, required 00000004", exp_pc);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
